// File: rtl/key_pkg.sv
// key_pkg: HID keycodes, default key table and key index names for the tracker
package key_pkg;
  localparam logic [7:0] KC_W        = 8'h1A;
  localparam logic [7:0] KC_A        = 8'h04;
  localparam logic [7:0] KC_S        = 8'h16;
  localparam logic [7:0] KC_D        = 8'h07;
  localparam logic [7:0] KC_E        = 8'h08;
  localparam logic [7:0] KC_SPACE    = 8'h2C;
  localparam logic [7:0] KC_UP       = 8'h52;
  localparam logic [7:0] KC_DOWN     = 8'h51;
  localparam logic [7:0] KC_RIGHT    = 8'h4F;
  localparam logic [7:0] KC_LEFT     = 8'h50;
  localparam logic [7:0] KC_ROLLOVER = 8'h01;
  localparam logic [9:0][7:0] DEFAULT_KEYS = {KC_LEFT, KC_RIGHT, KC_DOWN, KC_UP, KC_SPACE,
                                              KC_E, KC_D, KC_S, KC_A, KC_W};
  typedef enum logic [3:0] {
    K_W, K_A, K_S, K_D, K_E, K_SPACE, K_UP, K_DOWN, K_RIGHT, K_LEFT
  } key_idx_e;
endpackage

// File: rtl/key_event_tracker_if.sv
// key_event_tracker_if: keycode report in, per-key levels and event pulses out
interface key_event_tracker_if #(
  parameter int SLOTS = 4,
  parameter int NKEYS = 10
);
  localparam int IW = NKEYS > 1 ? $clog2(NKEYS) : 1;
  logic [8*SLOTS-1:0] keycode_i;
  logic               sample_en_i;
  logic [NKEYS-1:0]   held_o;
  logic [NKEYS-1:0]   press_o;
  logic [NKEYS-1:0]   release_o;
  logic [NKEYS-1:0]   rpt_o;
  logic               any_press_o;
  logic [IW-1:0]      first_idx_o;
  logic               rollover_o;
  modport master (
    output keycode_i, sample_en_i,
    input  held_o, press_o, release_o, rpt_o, any_press_o, first_idx_o, rollover_o
  );
  modport slave (
    input  keycode_i, sample_en_i,
    output held_o, press_o, release_o, rpt_o, any_press_o, first_idx_o, rollover_o
  );
endinterface

// File: rtl/key_repeat_timer.sv
// key_repeat_timer: one key's auto-repeat counter, pulsing rpt every PERIOD samples after DELAY
module key_repeat_timer #(
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_PERIOD = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_i,
  input  logic match_i,
  input  logic held_i,
  output logic rpt_o
);
  localparam int CW = REPEAT_DELAY > 0 ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam bit EN = REPEAT_DELAY != 0;
  localparam logic [CW-1:0] LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RELOAD = CW'(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY - REPEAT_PERIOD : 0);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rpt_q, rpt_d;
  // a press sample (match without prior held) or a release both restart the count
  always_comb begin
    cnt_d = cnt_q;
    rpt_d = 1'b0;
    if (sample_i) begin
      if (!match_i || !held_i) cnt_d = '0;
      else if (EN && cnt_q == LAST) begin
        cnt_d = RELOAD;
        rpt_d = 1'b1;
      end else cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rpt_q <= rpt_d;
    end
  end
  assign rpt_o = rpt_q;
endmodule

// File: rtl/key_event_tracker.sv
// key_event_tracker: matches HID report slots against a key table, producing held levels and event pulses
module key_event_tracker
  import key_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int NKEYS = 10,
  parameter logic [NKEYS-1:0][7:0] KEY_TABLE = DEFAULT_KEYS,
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_PERIOD = 6
) (
  input logic clk,
  input logic rst,
  key_event_tracker_if.slave bus
);
  localparam int IW = NKEYS > 1 ? $clog2(NKEYS) : 1;
  logic [NKEYS-1:0] match, rpt;
  logic [NKEYS-1:0] held_q, held_d, press_q, press_d, release_q, release_d;
  logic             roll, valid, rollover_q, rollover_d;
  logic [IW-1:0]    first_idx;
  always_comb begin
    match = '0;
    roll  = 1'b1;
    for (int k = 0; k < SLOTS; k++) roll = roll & (bus.keycode_i[8*k +: 8] == KC_ROLLOVER);
    for (int i = 0; i < NKEYS; i++)
      for (int k = 0; k < SLOTS; k++)
        if (KEY_TABLE[i] != 8'h00 && bus.keycode_i[8*k +: 8] == KEY_TABLE[i]) match[i] = 1'b1;
  end
  assign valid      = bus.sample_en_i & ~roll;
  assign held_d     = valid ? match : held_q;
  assign press_d    = valid ? match & ~held_q : '0;
  assign release_d  = valid ? ~match & held_q : '0;
  assign rollover_d = bus.sample_en_i ? roll : rollover_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q     <= '0;
      press_q    <= '0;
      release_q  <= '0;
      rollover_q <= 1'b0;
    end else begin
      held_q     <= held_d;
      press_q    <= press_d;
      release_q  <= release_d;
      rollover_q <= rollover_d;
    end
  end
  for (genvar g = 0; g < NKEYS; g++) begin : g_rpt
    key_repeat_timer #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .sample_i(valid),
      .match_i (match[g]),
      .held_i  (held_q[g]),
      .rpt_o   (rpt[g])
    );
  end
  always_comb begin
    first_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) if (press_q[i]) first_idx = IW'(i);
  end
  assign bus.held_o      = held_q;
  assign bus.press_o     = press_q;
  assign bus.release_o   = release_q;
  assign bus.rpt_o       = rpt;
  assign bus.any_press_o = |press_q;
  assign bus.first_idx_o = first_idx;
  assign bus.rollover_o  = rollover_q;
endmodule

// File: tb/tb_key_event_tracker.sv
// tb_key_event_tracker: directed and random reports checked against a sample-count reference model
module tb_key_event_tracker;
  import key_pkg::*;
  localparam int NK = 10;
  localparam int DLY = 3;
  localparam int PER = 2;
  localparam logic [NK-1:0][7:0] TBL = DEFAULT_KEYS & ~(80'hFF << 32);
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  bit [NK-1:0] e_held, e_press, e_rel, e_rpt;
  bit e_roll;
  int m_n[NK];
  key_event_tracker_if #(.SLOTS(4), .NKEYS(NK)) kif ();
  key_event_tracker #(
    .SLOTS(4), .NKEYS(NK), .KEY_TABLE(TBL), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(kif.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // n counts samples since the press sample; repeats fire at n = DLY, DLY+PER, ...
  task automatic model(input logic [31:0] kc, input bit en, input bit r);
    bit roll, mt;
    e_press = '0;
    e_rel = '0;
    e_rpt = '0;
    if (r) begin
      e_held = '0;
      e_roll = 1'b0;
      foreach (m_n[i]) m_n[i] = 0;
      return;
    end
    if (!en) return;
    roll = 1'b1;
    for (int k = 0; k < 4; k++) if (kc[8*k +: 8] != 8'h01) roll = 1'b0;
    e_roll = roll;
    if (roll) return;
    for (int i = 0; i < NK; i++) begin
      mt = 1'b0;
      for (int k = 0; k < 4; k++) if (TBL[i] != 8'h00 && kc[8*k +: 8] == TBL[i]) mt = 1'b1;
      if (mt && !e_held[i]) begin
        e_press[i] = 1'b1;
        m_n[i] = 0;
      end else if (mt) begin
        m_n[i]++;
        if (m_n[i] >= DLY && (m_n[i] - DLY) % PER == 0) e_rpt[i] = 1'b1;
      end else if (e_held[i]) e_rel[i] = 1'b1;
      e_held[i] = mt;
    end
  endtask
  task automatic step(input logic [31:0] kc, input bit en, input bit r);
    int fi;
    kif.keycode_i = kc;
    kif.sample_en_i = en;
    rst = r;
    @(posedge clk);
    model(kc, en, r);
    @(negedge clk);
    fi = 0;
    for (int i = NK - 1; i >= 0; i--) if (e_press[i]) fi = i;
    check("held", 32'(kif.held_o), 32'(e_held));
    check("press", 32'(kif.press_o), 32'(e_press));
    check("release", 32'(kif.release_o), 32'(e_rel));
    check("rpt", 32'(kif.rpt_o), 32'(e_rpt));
    check("any_press", 32'(kif.any_press_o), 32'(|e_press));
    check("first_idx", 32'(kif.first_idx_o), 32'(fi));
    check("rollover", 32'(kif.rollover_o), 32'(e_roll));
  endtask
  initial begin
    logic [7:0] r1, r2;
    logic [31:0] kc;
    kif.keycode_i = '0;
    kif.sample_en_i = 1'b0;
    step(32'h0, 1'b0, 1'b1);
    check("reset_held", 32'(kif.held_o), 32'h0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h001A_0000, 1'b1, 1'b0);
    check("t1_press", 32'(kif.press_o), 32'h001);
    check("t1_first", 32'(kif.first_idx_o), 32'h0);
    step(32'h0, 1'b0, 1'b0);
    check("t1_press_gone", 32'(kif.press_o), 32'h0);
    step(32'h0, 1'b1, 1'b0);
    check("t1_release", 32'(kif.release_o), 32'h001);
    step(32'h5004_2C07, 1'b1, 1'b0);
    check("t2_press", 32'(kif.press_o), 32'h22A);
    check("t2_first", 32'(kif.first_idx_o), 32'h1);
    step(32'h0, 1'b1, 1'b0);
    step(32'h0404_2C50, 1'b1, 1'b0);
    check("t2_dup_press", 32'(kif.press_o), 32'h222);
    step(32'h0, 1'b1, 1'b0);
    r1 = '0;
    for (int s = 0; s < 8; s++) begin
      step(32'h0000_001A, 1'b1, 1'b0);
      r1[s] = kif.rpt_o[0];
    end
    check("t3_rpt_pattern", 32'(r1), 32'hA8);
    step(32'h0, 1'b1, 1'b0);
    r2 = '0;
    for (int s = 0; s < 8; s++) begin
      step(s < 6 ? 32'h0000_001A : 32'h0, 1'b1, 1'b0);
      r2[s] = kif.rpt_o[0];
    end
    check("t3_rpt_released", 32'(r2), 32'h28);
    step(32'h0400_0000, 1'b1, 1'b0);
    step(32'h0400_0000, 1'b1, 1'b0);
    step(32'h0101_0101, 1'b1, 1'b0);
    check("t4_rollover", 32'(kif.rollover_o), 32'h1);
    check("t4_held", 32'(kif.held_o), 32'h002);
    step(32'h0400_0000, 1'b1, 1'b0);
    check("t4_rpt_after", 32'(kif.rpt_o), 32'h000);
    step(32'h0400_0000, 1'b1, 1'b0);
    check("t4_rpt_count_kept", 32'(kif.rpt_o), 32'h002);
    check("t4_roll_clear", 32'(kif.rollover_o), 32'h0);
    step(32'h0, 1'b1, 1'b0);
    step(32'h0000_1600, 1'b1, 1'b0);
    step(32'h0000_1600, 1'b1, 1'b1);
    check("t5_reset_held", 32'(kif.held_o), 32'h0);
    step(32'h0000_1600, 1'b1, 1'b0);
    check("t5_press", 32'(kif.press_o), 32'h004);
    check("t5_no_release", 32'(kif.release_o), 32'h0);
    step(32'h0, 1'b1, 1'b0);
    step(32'h0000_0008, 1'b1, 1'b0);
    check("t6_disabled", 32'(kif.held_o), 32'h0);
    step(32'h0, 1'b1, 1'b0);
    kc = '0;
    for (int it = 0; it < 2000; it++) begin
      int sel, k;
      if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 9);
        k = $urandom_range(0, 3);
        kc[8*k +: 8] = sel < 6 ? TBL[$urandom_range(0, NK - 1)] :
                       sel < 8 ? 8'h00 : 8'($urandom_range(0, 255));
      end
      step($urandom_range(0, 29) == 0 ? 32'h0101_0101 : kc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_event_tracker.md
# key_event_tracker

Parametrised keyboard front end that turns the USB HID keycode report into per-key state and event pulses for the game logic. It sits between the USB keycode register and the player/menu controllers. It compares each report slot against a configurable key table, with one table entry per key index. On each report sample it produces a level "held" vector and one-cycle press/release/repeat pulses. Each key has its own auto-repeat timer.

## Interface
- SLOTS, 4: number of 8-bit keycode slots in the report.
- NKEYS, 10: number of tracked keys (table entries).
- KEY_TABLE, key_pkg::DEFAULT_KEYS: NKEYS×8-bit codes; index i is the code for key i.
- REPEAT_DELAY, 30: samples from press to first repeat pulse; 0 disables repeat.
- REPEAT_PERIOD, 6: samples between subsequent repeat pulses; must be ≥1.
- Clk  in  1  system clock, single domain.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8*SLOTS  report; slot k = keycode[8k+7:8k].
- sample_en  in  1  one-cycle strobe: capture keycode this edge.
- held  out  NKEYS  key i currently down (registered level).
- press  out  NKEYS  one-cycle pulse on up→down.
- release  out  NKEYS  one-cycle pulse on down→up.
- rpt  out  NKEYS  one-cycle auto-repeat pulse.
- any_press  out  1  OR of press, same cycle.
- first_idx  out  $clog2(NKEYS)  lowest index with press set; 0 when none.
- rollover  out  1  last sample was a rollover-error report.

## Operation
- Match: key i is matched when any slot equals KEY_TABLE[i]. A table code of 8'h00 never matches. A code repeated across slots counts once.
- Rollover: if every slot equals 8'h01, the sample is discarded.
  - held, counters and pulses are unchanged by a discarded sample.
  - rollover is set to 1 until the next non-rollover sample.
- On a sample_en edge with a valid sample: held ← match.
  - press ← match & ~held.
  - release ← ~match & held.
- Pulses (press, release, rpt, any_press) are 0 on every cycle not immediately following a sample edge.
- Repeat (per key, when REPEAT_DELAY≠0):
  - The counter clears on the press sample.
  - Each later sample with the key still matched increments the counter.
  - rpt pulses when the count reaches REPEAT_DELAY. The counter is then reloaded to REPEAT_DELAY−REPEAT_PERIOD, so pulses recur every REPEAT_PERIOD samples.
  - Release clears the counter.
  - The counter saturates and never wraps.
- press and rpt are never asserted together for the same key.
- Simultaneous press of several keys: all press bits are set, and first_idx selects the lowest index.

## Timing
- Latency: outputs update on the edge after the Clk edge where sample_en=1, i.e. they are valid one cycle after the sample.
- sample_en held high on consecutive cycles means every cycle is a sample. No minimum spacing is required.
- Reset: held, press, release, rpt, any_press, first_idx, rollover and all counters are 0. Reset has priority over sample_en on the same edge.
- Reset mid-hold: state is lost. A key still present in the report produces press (not rpt) on the first sample after reset deasserts, and no release pulse is generated.
- Counter width: $clog2(REPEAT_DELAY+1). Saturation occurs at the maximum count.

## Structure
- key_pkg holds:
  - HID code constants: W 8'h1A, A 8'h04, S 8'h16, D 8'h07, E 8'h08, SPACE 8'h2C, UP 8'h52, DOWN 8'h51, RIGHT 8'h4F, LEFT 8'h50, ROLLOVER 8'h01.
  - DEFAULT_KEYS in that order (index 0 = W … 9 = LEFT).
  - Key index enum.
- Sub-module key_repeat_timer holds one key's counter and rpt logic. It is instantiated NKEYS times in a generate loop.
- Matching, rollover detection and the first_idx priority encoder stay in the top module.

## Test plan
- Reset, then sample a report of 0x1A in slot 2 → held[0]=1, press[0]=1 for exactly one cycle, any_press=1, first_idx=0. On the next sample with an all-zero report → release[0]=1 and held[0]=0.
- Report 0x50_04_2C_07 → press bits 9, 1, 5 and 3 are set together, and first_idx=1. Duplicate 0x04 in two slots → identical result.
- Override REPEAT_DELAY=3, REPEAT_PERIOD=2. Hold W from sample 0 → rpt[0] at samples 3, 5 and 7 only. Release at sample 6 → no pulse at 7, and the counter is cleared.
- Hold A, then issue an all-0x01 report → rollover=1 with held, pulses and the counter unchanged. A following normal report → rollover=0.
- Hold S, then assert Reset for one cycle on a sample edge → all outputs are 0. The next sample still containing 0x16 → press[2]=1 and no release.
- Set KEY_TABLE entry 4 to 8'h00 and send an all-zero report → held stays 0 and no pulses occur.
